// File: rtl/mem_port_if.sv
// Requester-side bus of mem_port_arbiter: per-requester request/address/data in, one-hot grant/completion out.
//
// Handshake: req[i] is held high until gnt[i] pulses for one cycle, which means the request was latched.
// rvalid[i] later pulses for one cycle and marks the completion; for reads, rdata is valid in that cycle.
interface mem_port_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [2:0]    req;
  logic [2:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] wdata2;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch (0), data (1) and debug loader (2), one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority debug > fetch > data.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_port_if.slave     bus,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wren,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q,
  output logic          busy,
  output logic [1:0]    owner,
  output logic [1:0]    state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(RAM_LAT - 1);

  state_t        state, state_n;
  logic [1:0]    wait_cnt;
  logic          we_lat;
  logic [DW-1:0] rdata_q;
  logic [1:0]    win;
  logic          win_vld;
  logic          take;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr, c0, c1, c2;

  // Search order starts one past the last granted requester.
  always_comb begin
    c0 = 2'd1;
    c1 = 2'd2;
    c2 = 2'd0;
    case (rr_ptr)
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      2'd2:    begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
      default: ;
    endcase
    win = c2;
    if (bus.req[c0])      win = c0;
    else if (bus.req[c1]) win = c1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_ptr <= 2'd0;
    else if (state == ISSUE) rr_ptr <= owner;
  end
`else
  always_comb begin
    win = 2'd1;
    if (bus.req[2])      win = 2'd2;
    else if (bus.req[0]) win = 2'd0;
  end
`endif

  assign win_vld = |bus.req;

  always_comb begin
    win_addr  = bus.addr2;
    win_wdata = bus.wdata2;
    case (win)
      2'd0:    begin win_addr = bus.addr0; win_wdata = bus.wdata0; end
      2'd1:    begin win_addr = bus.addr1; win_wdata = bus.wdata1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Arbitration happens in IDLE and DONE, so a held request can follow DONE straight into ISSUE.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    case (state)
      IDLE:  if (win_vld) begin state_n = ISSUE; take = 1'b1; end
      ISSUE: state_n = WAIT;
      WAIT:  if (wait_cnt == LAST_WAIT) state_n = DONE;
      DONE:  begin take = win_vld; state_n = win_vld ? ISSUE : IDLE; end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= 2'd0;
      we_lat   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      wait_cnt <= 2'd0;
      rdata_q  <= '0;
    end else begin
      // The RAM-side registers load on the arbitration edge so they are stable throughout ISSUE.
      if (take) begin
        owner    <= win;
        we_lat   <= bus.we[win];
        mem_addr <= win_addr;
        mem_data <= win_wdata;
        mem_wren <= bus.we[win];
      end else begin
        mem_wren <= 1'b0;
      end
      if (state == ISSUE)     wait_cnt <= 2'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (state == WAIT && wait_cnt == LAST_WAIT && !we_lat) rdata_q <= mem_q;
    end
  end

  assign bus.gnt    = (state == ISSUE) ? (3'b001 << owner) : 3'b000;
  assign bus.rvalid = (state == DONE)  ? (3'b001 << owner) : 3'b000;
  assign bus.rdata  = rdata_q;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
endmodule
